// File: rtl/rf_write_arbiter.sv
// Two-requester register-file write arbiter. The requester granted last loses a tie,
// and every output is registered, so a grant decided at edge N shows up after edge N.
module rf_write_arbiter #(
  parameter bit R0_PROTECT = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_A,
  input  logic [4:0]  ADDR_A,
  input  logic [31:0] DATA_A,
  input  logic        REQ_B,
  input  logic [4:0]  ADDR_B,
  input  logic [31:0] DATA_B,
  output logic        ACK_A,
  output logic        ACK_B,
  output logic        W_EN,
  output logic [4:0]  W_ADDR,
  output logic [31:0] W_DATA,
  output logic [31:0] W_SEL,
  output logic [15:0] WR_CNT
);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t      state_q, state_d;
  logic        last_q;   // most recent grant: 0 = A, 1 = B
  logic        gnt_q;    // requester being written in the current WRITE cycle
  logic        req_a_ok, req_b_ok;
  logic        gnt_vld, gnt_id;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;
  logic        sel_wr;
  logic [31:0] sel_onehot;

  // The requester being acked this cycle still shows REQ high; mask it so it
  // is not granted twice for one request.
  always_comb begin
    req_a_ok = REQ_A && !(state_q == WRITE && gnt_q == 1'b0);
    req_b_ok = REQ_B && !(state_q == WRITE && gnt_q == 1'b1);
    gnt_vld  = 1'b0;
    gnt_id   = last_q;
    state_d  = IDLE;
    if (req_a_ok && req_b_ok) begin
      gnt_vld = 1'b1;
      gnt_id  = ~last_q;
    end else if (req_a_ok) begin
      gnt_vld = 1'b1;
      gnt_id  = 1'b0;
    end else if (req_b_ok) begin
      gnt_vld = 1'b1;
      gnt_id  = 1'b1;
    end
    if (gnt_vld) state_d = WRITE;
  end

  always_comb begin
    sel_addr   = gnt_id ? ADDR_B : ADDR_A;
    sel_data   = gnt_id ? DATA_B : DATA_A;
    sel_wr     = gnt_vld && !(R0_PROTECT && sel_addr == 5'd0);
    sel_onehot = 32'd1 << sel_addr;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      ACK_A   <= 1'b0;
      ACK_B   <= 1'b0;
      W_EN    <= 1'b0;
      W_ADDR  <= '0;
      W_DATA  <= '0;
      W_SEL   <= '0;
    end else begin
      state_q <= state_d;
      ACK_A   <= gnt_vld && !gnt_id;
      ACK_B   <= gnt_vld && gnt_id;
      W_EN    <= sel_wr;
      W_SEL   <= sel_wr ? sel_onehot : 32'd0;
      if (gnt_vld) begin
        last_q <= gnt_id;
        gnt_q  <= gnt_id;
        W_ADDR <= sel_addr;
        W_DATA <= sel_data;
      end
    end
  end

  // Counts strobes already on the outputs, so it lags W_EN by one cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      WR_CNT <= '0;
    else if (W_EN && WR_CNT != 16'hFFFF)
      WR_CNT <= WR_CNT + 16'd1;
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: expected writes are queued when requests are
// driven and checked against each ACK pulse by a negedge monitor.
module tb_rf_write_arbiter;

  logic        CLK, RST;
  logic        REQ_A, REQ_B;
  logic [4:0]  ADDR_A, ADDR_B;
  logic [31:0] DATA_A, DATA_B;
  logic        ACK_A, ACK_B, W_EN;
  logic [4:0]  W_ADDR;
  logic [31:0] W_DATA, W_SEL;
  logic [15:0] WR_CNT;

  typedef struct packed {
    logic        who;   // 0 = A, 1 = B
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  bit   bulk  = 0;

  rf_write_arbiter #(.R0_PROTECT(1'b1)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_A(REQ_A), .ADDR_A(ADDR_A), .DATA_A(DATA_A),
    .REQ_B(REQ_B), .ADDR_B(ADDR_B), .DATA_B(DATA_B),
    .ACK_A(ACK_A), .ACK_B(ACK_B),
    .W_EN(W_EN), .W_ADDR(W_ADDR), .W_DATA(W_DATA), .W_SEL(W_SEL), .WR_CNT(WR_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    #2;
    RST = 1'b1;
  endtask

  task automatic push(input logic who, input logic en, input logic [4:0] addr, input logic [31:0] data);
    exp_t e;
    e.who = who; e.en = en; e.addr = addr; e.data = data;
    q.push_back(e);
  endtask

  // Every ACK must match the next queued write; with no ACK there must be no strobe.
  always @(negedge CLK) begin
    if (RST && !bulk) begin
      if (ACK_A || ACK_B) begin
        chk("ack_onehot", {31'd0, ACK_A & ACK_B}, 32'd0);
        if (q.size() == 0) begin
          chk("ack_expected", {30'd0, ACK_A, ACK_B}, 32'd0);
        end else begin
          exp_t e;
          logic [31:0] one;
          e   = q.pop_front();
          one = 32'd1;
          chk("sb_ack_a", {31'd0, ACK_A}, {31'd0, !e.who});
          chk("sb_ack_b", {31'd0, ACK_B}, {31'd0, e.who});
          chk("sb_wen", {31'd0, W_EN}, {31'd0, e.en});
          chk("sb_waddr", {27'd0, W_ADDR}, {27'd0, e.addr});
          chk("sb_wdata", W_DATA, e.data);
          chk("sb_wsel", W_SEL, e.en ? (one << e.addr) : 32'd0);
        end
      end else begin
        chk("idle_wen", {31'd0, W_EN}, 32'd0);
        chk("idle_wsel", W_SEL, 32'd0);
      end
    end
  end

  initial begin
    RST = 1'b0;
    REQ_A = 0; REQ_B = 0; ADDR_A = 0; ADDR_B = 0; DATA_A = 0; DATA_B = 0;
    #1;
    chk("rst_wen", {31'd0, W_EN}, 32'd0);
    chk("rst_ack", {30'd0, ACK_A, ACK_B}, 32'd0);
    chk("rst_waddr", {27'd0, W_ADDR}, 32'd0);
    chk("rst_wdata", W_DATA, 32'd0);
    chk("rst_wsel", W_SEL, 32'd0);
    chk("rst_cnt", {16'd0, WR_CNT}, 32'd0);
    tick(); tick();

    // Single write from A after reset release
    do_reset();
    REQ_A = 1; ADDR_A = 5'd5; DATA_A = 32'hDEADBEEF;
    push(1'b0, 1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    chk("s1_wen", {31'd0, W_EN}, 32'd1);
    chk("s1_waddr", {27'd0, W_ADDR}, 32'd5);
    chk("s1_wsel", W_SEL, 32'h20);
    chk("s1_ack_a", {31'd0, ACK_A}, 32'd1);
    chk("s1_cnt0", {16'd0, WR_CNT}, 32'd0);
    REQ_A = 0;
    tick();
    chk("s1_cnt1", {16'd0, WR_CNT}, 32'd1);
    chk("s1_ack_drop", {31'd0, ACK_A}, 32'd0);

    // Both requesters held from reset: strict A,B alternation, data sampled at grant
    tick();
    RST = 1'b0;
    REQ_A = 1; ADDR_A = 5'd3; REQ_B = 1; ADDR_B = 5'd7;
    #2;
    RST = 1'b1;
    for (int i = 0; i < 6; i++) begin
      DATA_A = 32'hA000_0000 + i;
      DATA_B = 32'hB000_0000 + i;
      if (i % 2 == 0) push(1'b0, 1'b1, 5'd3, 32'hA000_0000 + i);
      else            push(1'b1, 1'b1, 5'd7, 32'hB000_0000 + i);
      tick();
      chk("s2_wen", {31'd0, W_EN}, 32'd1);
      chk("s2_ack_b", {31'd0, ACK_B}, {31'd0, i % 2 == 1});
    end
    REQ_A = 0; REQ_B = 0;
    tick();
    chk("s2_cnt", {16'd0, WR_CNT}, 32'd6);
    chk("s2_idle", {31'd0, W_EN}, 32'd0);

    // R0 write from B: acked, not issued
    REQ_B = 1; ADDR_B = 5'd0; DATA_B = 32'h1234_5678;
    push(1'b1, 1'b0, 5'd0, 32'h1234_5678);
    tick();
    chk("s3_ack_b", {31'd0, ACK_B}, 32'd1);
    chk("s3_wen", {31'd0, W_EN}, 32'd0);
    chk("s3_wsel", W_SEL, 32'd0);
    REQ_B = 0;
    tick();
    chk("s3_ack_once", {31'd0, ACK_B}, 32'd0);
    chk("s3_cnt", {16'd0, WR_CNT}, 32'd6);

    // A alone: one write every two cycles, address changes while waiting
    REQ_A = 1;
    for (int i = 0; i < 6; i++) begin
      ADDR_A = 5'(10 + i);
      DATA_A = 32'hC000_0000 + i;
      if (i % 2 == 0) push(1'b0, 1'b1, 5'(10 + i), 32'hC000_0000 + i);
      tick();
      chk("s4_wen", {31'd0, W_EN}, {31'd0, i % 2 == 0});
      chk("s4_ack_a", {31'd0, ACK_A}, {31'd0, i % 2 == 0});
    end

    // Tie after an A grant goes to B; A withdraws before being granted
    REQ_A = 1; ADDR_A = 5'd21; DATA_A = 32'h0BAD_0BAD;
    REQ_B = 1; ADDR_B = 5'd20; DATA_B = 32'h600D_600D;
    push(1'b1, 1'b1, 5'd20, 32'h600D_600D);
    tick();
    chk("s5_ack_b", {31'd0, ACK_B}, 32'd1);
    chk("s5_ack_a", {31'd0, ACK_A}, 32'd0);
    REQ_A = 0; REQ_B = 0;
    tick();
    chk("s5_withdrawn", {31'd0, ACK_A}, 32'd0);
    tick();
    chk("s5_cnt", {16'd0, WR_CNT}, 32'd10);

    // Reset mid-WRITE clears outputs without a clock; A first afterwards, same address twice
    REQ_A = 1; ADDR_A = 5'd9; DATA_A = 32'h5555_5555;
    tick();
    chk("s6_pre_wen", {31'd0, W_EN}, 32'd1);
    chk("s6_pre_ack", {31'd0, ACK_A}, 32'd1);
    #1;
    RST = 1'b0;
    REQ_A = 0;
    #1;
    chk("s6_wen", {31'd0, W_EN}, 32'd0);
    chk("s6_ack", {30'd0, ACK_A, ACK_B}, 32'd0);
    chk("s6_wsel", W_SEL, 32'd0);
    chk("s6_cnt", {16'd0, WR_CNT}, 32'd0);
    REQ_A = 1; ADDR_A = 5'd4; DATA_A = 32'h1111_1111;
    REQ_B = 1; ADDR_B = 5'd4; DATA_B = 32'h2222_2222;
    RST = 1'b1;
    push(1'b0, 1'b1, 5'd4, 32'h1111_1111);
    push(1'b1, 1'b1, 5'd4, 32'h2222_2222);
    tick();
    chk("s6_first_a", {31'd0, ACK_A}, 32'd1);
    tick();
    chk("s6_then_b", {31'd0, ACK_B}, 32'd1);
    chk("s6_last_wins", W_DATA, 32'h2222_2222);
    REQ_A = 0; REQ_B = 0;
    tick();
    chk("s6_cnt2", {16'd0, WR_CNT}, 32'd2);

    // Counter saturation under continuous back-to-back writes
    do_reset();
    bulk = 1;
    REQ_A = 1; ADDR_A = 5'd1; REQ_B = 1; ADDR_B = 5'd2;
    repeat (65535) tick();
    chk("s7_cnt_pre", {16'd0, WR_CNT}, 32'd65534);
    tick();
    chk("s7_cnt_max", {16'd0, WR_CNT}, 32'h0000FFFF);
    repeat (4) begin
      tick();
      chk("s7_wen", {31'd0, W_EN}, 32'd1);
      chk("s7_cnt_sat", {16'd0, WR_CNT}, 32'h0000FFFF);
    end
    REQ_A = 0; REQ_B = 0;
    tick();
    tick();
    bulk = 0;
    chk("s7_idle", {31'd0, W_EN}, 32'd0);

    chk("sb_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter: R0_PROTECT, default 1, 1 = writes addressed to R0 are acknowledged but never issued.
REQ-002 Port: CLK  input  1  system clock, all state updates on rising edge.
REQ-003 Port: RST  input  1  asynchronous, active-low reset.
REQ-004 Port: REQ_A  input  1  requester A write request, level, held until ACK_A.
REQ-005 Port: ADDR_A  input  5  requester A destination register.
REQ-006 Port: DATA_A  input  32  requester A write data.
REQ-007 Port: REQ_B / ADDR_B / DATA_B  input  1/5/32  requester B, same meaning as A.
REQ-008 Port: ACK_A, ACK_B  output  1 each  one-cycle acknowledge pulse.
REQ-009 Port: W_EN  output  1  register-file write strobe.
REQ-010 Port: W_ADDR  output  5  register-file write address.
REQ-011 Port: W_DATA  output  32  register-file write data.
REQ-012 Port: W_SEL  output  32  one-hot row load, bit W_ADDR set when W_EN=1, all zero otherwise.
REQ-013 Port: WR_CNT  output  16  count of issued writes.

Function
REQ-014 FSM states: IDLE, WRITE; register LAST (1 bit, 0=A, 1=B) records most recent grant.
REQ-015 All outputs registered; decision made in cycle N appears on outputs in cycle N+1.
REQ-016 IDLE, one requester active: grant it; both active: grant requester != LAST; none: stay IDLE.
REQ-017 On grant: next cycle state=WRITE, ACK of granted requester=1, W_ADDR/W_DATA = that requester's ADDR/DATA sampled at decision edge, LAST updated.
REQ-018 In WRITE with grant g: g is excluded from arbitration that cycle; if other requester active, grant it (WRITE again, back-to-back), else go IDLE.
REQ-019 Throughput: both requesters continuously active -> one write per cycle, strictly alternating; single requester -> at most one write per two cycles.
REQ-020 ACK_A and ACK_B never both 1; each is high exactly one cycle per accepted request.
REQ-021 W_EN = 1 in WRITE unless R0_PROTECT=1 and W_ADDR=0; ACK still issued for R0 writes.
REQ-022 W_SEL = 32'b0 whenever W_EN=0; never more than one bit set.
REQ-023 WR_CNT increments by 1 on each cycle with W_EN=1; saturates at 16'hFFFF, no wrap.
REQ-024 Same address from both requesters in consecutive writes: both issued in grant order; later write wins, no merging.
REQ-025 Requester changing ADDR/DATA before its ACK is legal; the value sampled at its grant edge is written.
REQ-026 Requester may drop REQ before ACK; a request not yet granted is withdrawn with no write and no ACK.
REQ-027 W_EN=0 in IDLE; W_ADDR/W_DATA hold last values when W_EN=0.

Reset
REQ-028 RST=0 asynchronously forces state=IDLE, LAST=1 (A has first priority), ACK_A=ACK_B=0, W_EN=0, W_ADDR=0, W_DATA=0, W_SEL=0, WR_CNT=0.
REQ-029 Reset asserted during WRITE aborts it immediately: strobe and ACK drop without waiting for a clock; pending request is not acknowledged.
REQ-030 After RST rises, first arbitration occurs on the first rising CLK edge with RST=1.

Verification
REQ-031 Reset release, REQ_A=1, ADDR_A=5, DATA_A=32'hDEADBEEF -> next cycle W_EN=1, W_ADDR=5, W_SEL=32'h20, ACK_A=1, WR_CNT becomes 1 the cycle after.
REQ-032 REQ_A and REQ_B held high from reset, A addr 3, B addr 7 -> writes alternate A,B,A,B on consecutive cycles, ACKs alternate, first grant A.
REQ-033 REQ_B=1 with ADDR_B=0, R0_PROTECT=1 -> ACK_B=1 for one cycle, W_EN=0, W_SEL=0, WR_CNT unchanged.
REQ-034 Only REQ_A held high continuously -> W_EN pattern 1,0,1,0 and ACK_A pulses every second cycle.
REQ-035 RST driven low mid-WRITE between clock edges -> W_EN, ACK_x, W_SEL, WR_CNT go 0 immediately; after release, A is granted first.
REQ-036 Force 65536 writes -> WR_CNT holds 16'hFFFF on subsequent writes.
